// File: rtl/sccb_master.sv
// sccb_master: OCP-style register slave that runs a camera SCCB (I2C-like) master.
// The host programs DEV_ID/REG_ADDR/WDATA, then kicks a 3-phase write or a
// 2+2-phase read through CTRL; STATUS and RDATA report the outcome.
// Optional feature macro: SCCB_ACK_CHECK_EN -- when defined, a high ACK bit
// aborts the transfer (straight to STOP) and sets the sticky nack flag.

module sccb_master #(
  parameter int unsigned CLK_DIV = 120  // clk cycles per quarter SCCB bit, 2..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sccb_MCmd,
  input  logic [7:0] sccb_MAddr,
  input  logic [7:0] sccb_MData,
  output logic       sccb_SCmdAccept,
  output logic [7:0] sccb_SData,
  output logic [1:0] sccb_SResp,
  output logic       sio_c,
  output logic       siod_o,
  output logic       siod_oe,
  input  logic       siod_i,
  output logic       busy
);

  localparam logic [2:0] CmdIdle  = 3'b000;
  localparam logic [2:0] CmdWrite = 3'b001;
  localparam logic [2:0] CmdRead  = 3'b010;

  localparam logic [1:0] RespNull = 2'b00;
  localparam logic [1:0] RespDva  = 2'b01;
  localparam logic [1:0] RespErr  = 2'b11;

  localparam logic [7:0] AddrDevId  = 8'h00;
  localparam logic [7:0] AddrReg    = 8'h01;
  localparam logic [7:0] AddrWdata  = 8'h02;
  localparam logic [7:0] AddrCtrl   = 8'h03;
  localparam logic [7:0] AddrStatus = 8'h04;
  localparam logic [7:0] AddrRdata  = 8'h05;

  localparam logic [7:0] DivMax = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StTxByte,
    StTxAck,
    StRxByte,
    StTxNa,
    StStop,
    StGap
  } state_e;

  // Bus side
  logic       cmd_ok, addr_ok;
  logic       wr_en, rd_en, status_rd;
  logic       start_req, start_read;
  logic [7:0] rd_val;

  logic [1:0] resp_q;
  logic [7:0] sdata_q;
  logic [7:0] dev_id_q, reg_addr_q, wdata_q, rdata_q;
  logic       done_q, nack_q;

  // Transfer engine
  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;     // quarter of the current SCCB bit
  logic [2:0] bit_q, bit_d;         // bit index within the byte, MSB first
  logic [1:0] byte_q, byte_d;       // byte index within the current phase group
  logic       rd_op_q, rd_op_d;     // transaction is a read
  logic       restart_q, restart_d; // second (post repeated-start) half of a read
  logic       abort_q, abort_d;     // NACK seen, finish with STOP then idle
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] lat_id_q, lat_id_d;   // device ID without the R/W bit
  logic [7:0] lat_reg_q, lat_reg_d;
  logic [7:0] lat_wdata_q, lat_wdata_d;
  logic [7:0] rx_q, rx_d;
`ifdef SCCB_ACK_CHECK_EN
  logic       ack_q, ack_d;
`endif

  logic       tick;
  logic       ack_bad;
  logic       fsm_done, fsm_nack, rdata_load;
  logic [7:0] tx_byte;
  logic [1:0] last_byte;

  assign sccb_SResp = resp_q;
  assign sccb_SData = sdata_q;
  assign busy       = (state_q != StIdle);

  // Command decode; a pending response cycle blocks acceptance.
  always_comb begin
    sccb_SCmdAccept = !reset && (sccb_MCmd != CmdIdle) && (resp_q == RespNull);
    addr_ok    = (sccb_MAddr <= AddrRdata);
    cmd_ok     = (sccb_MCmd == CmdWrite) || (sccb_MCmd == CmdRead);
    wr_en      = sccb_SCmdAccept && (sccb_MCmd == CmdWrite) && addr_ok;
    rd_en      = sccb_SCmdAccept && (sccb_MCmd == CmdRead) && addr_ok;
    status_rd  = rd_en && (sccb_MAddr == AddrStatus);
    start_req  = wr_en && (sccb_MAddr == AddrCtrl) && !busy && (sccb_MData[1:0] != 2'b00);
    // Write wins when both start bits are set.
    start_read = !sccb_MData[0];
    rd_val     = 8'h00;
    case (sccb_MAddr)
      AddrDevId:  rd_val = dev_id_q;
      AddrReg:    rd_val = reg_addr_q;
      AddrWdata:  rd_val = wdata_q;
      AddrStatus: rd_val = {5'b0, done_q, nack_q, busy};
      AddrRdata:  rd_val = rdata_q;
      default:    rd_val = 8'h00;
    endcase
  end

  // Register file, sticky status flags and the one-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_q     <= RespNull;
      sdata_q    <= 8'h00;
      dev_id_q   <= 8'h00;
      reg_addr_q <= 8'h00;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      resp_q  <= RespNull;
      sdata_q <= 8'h00;
      if (sccb_SCmdAccept) begin
        if (cmd_ok && addr_ok) begin
          resp_q <= RespDva;
          if (rd_en) sdata_q <= rd_val;
        end else begin
          resp_q <= RespErr;
        end
      end
      if (wr_en) begin
        case (sccb_MAddr)
          AddrDevId: dev_id_q   <= sccb_MData;
          AddrReg:   reg_addr_q <= sccb_MData;
          AddrWdata: wdata_q    <= sccb_MData;
          default: ;
        endcase
      end
      if (start_req || status_rd) begin
        done_q <= 1'b0;
        nack_q <= 1'b0;
      end
      // Engine events take priority so a completion is never lost to a read.
      if (fsm_done)   done_q  <= 1'b1;
      if (fsm_nack)   nack_q  <= 1'b1;
      if (rdata_load) rdata_q <= rx_q;
    end
  end

  // Transfer engine state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_q     <= 2'd0;
      bit_q       <= 3'd0;
      byte_q      <= 2'd0;
      rd_op_q     <= 1'b0;
      restart_q   <= 1'b0;
      abort_q     <= 1'b0;
      cnt_q       <= 8'h00;
      lat_id_q    <= 7'h00;
      lat_reg_q   <= 8'h00;
      lat_wdata_q <= 8'h00;
      rx_q        <= 8'h00;
`ifdef SCCB_ACK_CHECK_EN
      ack_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      rd_op_q     <= rd_op_d;
      restart_q   <= restart_d;
      abort_q     <= abort_d;
      cnt_q       <= cnt_d;
      lat_id_q    <= lat_id_d;
      lat_reg_q   <= lat_reg_d;
      lat_wdata_q <= lat_wdata_d;
      rx_q        <= rx_d;
`ifdef SCCB_ACK_CHECK_EN
      ack_q       <= ack_d;
`endif
    end
  end

  // Transfer engine next state: every state advances only on a quarter-bit tick.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    rd_op_d     = rd_op_q;
    restart_d   = restart_q;
    abort_d     = abort_q;
    lat_id_d    = lat_id_q;
    lat_reg_d   = lat_reg_q;
    lat_wdata_d = lat_wdata_q;
    rx_d        = rx_q;
    fsm_done    = 1'b0;
    fsm_nack    = 1'b0;
    rdata_load  = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
    ack_d       = ack_q;
    ack_bad     = ack_q;
`else
    ack_bad     = 1'b0;
`endif

    tick  = (state_q != StIdle) && (cnt_q == DivMax);
    cnt_d = (state_q == StIdle || tick) ? 8'h00 : cnt_q + 8'd1;
    if (tick) phase_d = phase_q + 2'd1;

    // Reads send ID and REG_ADDR before the restart; writes add WDATA.
    last_byte = rd_op_q ? 2'd1 : 2'd2;

    case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d     = StStart;
          phase_d     = 2'd0;
          bit_d       = 3'd0;
          byte_d      = 2'd0;
          rd_op_d     = start_read;
          restart_d   = 1'b0;
          abort_d     = 1'b0;
          lat_id_d    = dev_id_q[7:1];
          lat_reg_d   = reg_addr_q;
          lat_wdata_d = wdata_q;
        end
      end
      StStart: begin
        if (tick && phase_q == 2'd1) begin
          state_d = StTxByte;
          phase_d = 2'd0;
          bit_d   = 3'd0;
        end
      end
      StTxByte: begin
        if (tick && phase_q == 2'd3) begin
          if (bit_q == 3'd7) begin
            state_d = StTxAck;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StTxAck: begin
`ifdef SCCB_ACK_CHECK_EN
        if (tick && phase_q == 2'd2) ack_d = siod_i;
`endif
        if (tick && phase_q == 2'd3) begin
          if (ack_bad) begin
            state_d  = StStop;
            abort_d  = 1'b1;
            fsm_nack = 1'b1;
          end else if (restart_q) begin
            state_d = StRxByte;
          end else if (byte_q == last_byte) begin
            state_d = StStop;
          end else begin
            state_d = StTxByte;
            byte_d  = byte_q + 2'd1;
          end
        end
      end
      StRxByte: begin
        if (tick && phase_q == 2'd2) rx_d = {rx_q[6:0], siod_i};
        if (tick && phase_q == 2'd3) begin
          if (bit_q == 3'd7) begin
            state_d    = StTxNa;
            bit_d      = 3'd0;
            rdata_load = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StTxNa: begin
        if (tick && phase_q == 2'd3) state_d = StStop;
      end
      StStop: begin
        if (tick && phase_q == 2'd1) begin
          phase_d = 2'd0;
          if (rd_op_q && !restart_q && !abort_q) begin
            state_d   = StGap;
            restart_d = 1'b1;
            byte_d    = 2'd0;
          end else begin
            state_d  = StIdle;
            fsm_done = 1'b1;
          end
        end
      end
      StGap: begin
        if (tick && phase_q == 2'd3) begin
          state_d = StStart;
          phase_d = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin decode: sio_c is low in q0/q1 and high in q2/q3 of every data bit.
  always_comb begin
    if (restart_q) begin
      tx_byte = {lat_id_q, 1'b1};
    end else begin
      case (byte_q)
        2'd0:    tx_byte = {lat_id_q, 1'b0};
        2'd1:    tx_byte = lat_reg_q;
        default: tx_byte = lat_wdata_q;
      endcase
    end
    sio_c   = 1'b1;
    siod_o  = 1'b1;
    siod_oe = 1'b1;
    case (state_q)
      StStart: begin
        siod_o = 1'b0;
      end
      StTxByte: begin
        sio_c  = phase_q[1];
        siod_o = tx_byte[3'd7 - bit_q];
      end
      StTxAck, StRxByte: begin
        sio_c   = phase_q[1];
        siod_oe = 1'b0;
      end
      StTxNa: begin
        sio_c = phase_q[1];
      end
      StStop: begin
        // Pull data low under a low clock, raise the clock, then data rises on exit.
        sio_c  = (phase_q == 2'd1);
        siod_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
